// File: rtl/multichannel_feedback_reverb_if.sv
// Sample stream bundle for the feedback reverb: samples in, mixed samples out.
// The reverb core is the slave; the upstream/downstream stages form the master side.
interface multichannel_feedback_reverb_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_WIDTH   = 1
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  din_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [CH_WIDTH-1:0]   dout_chan;
    logic                  dout_last;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, dout_chan, dout_last
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, dout_chan, dout_last
    );
endinterface

// File: rtl/multichannel_feedback_reverb.sv
// Interleaved multichannel feedback-comb reverb: w = x + g_fb*w[n-D], y = dry*x + wet*w[n-D].
// One sample in flight at a time; the delay line sits in a 1R1W RAM addressed {ptr, ch}.
module multichannel_feedback_reverb #(
    parameter int G_DATA_WIDTH       = 16,
    parameter int G_NUM_CH           = 2,
    parameter int G_DELAY_DEPTH_LOG2 = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          bypass,
    input  logic [15:0]                   feedback_gain,
    input  logic [15:0]                   wet_gain,
    input  logic [15:0]                   dry_gain,
    input  logic [G_DELAY_DEPTH_LOG2-1:0] delay_len,
    output logic                          busy_clearing,
    multichannel_feedback_reverb_if.slave stream
);
    localparam int W  = G_DATA_WIDTH;
    localparam int CW = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1;
    localparam int DW = G_DELAY_DEPTH_LOG2;
    localparam int AW = DW + CW;
    localparam int PW = W + 17;
    localparam int SW = PW + 1;
    localparam logic [CW-1:0] LAST_CH = CW'(G_NUM_CH - 1);

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        hi = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
        lo = ~hi;
        if (v > hi) begin
            return hi[W-1:0];
        end else if (v < lo) begin
            return lo[W-1:0];
        end else begin
            return v[W-1:0];
        end
    endfunction

    logic [2:0]          state_r, state_next;
    logic [CW-1:0]       ch_r, clr_ch_r;
    logic [DW-1:0]       ptr_r, clr_ptr_r;
    logic [AW-1:0]       rd_addr_r, wr_addr_s;
    logic signed [W-1:0] x_r, rd_data_r, wr_data_s, dout_r;
    logic [15:0]         fb_r, wet_r, dry_r;
    logic                bypass_r, wr_en_s, accept_s, clr_last_s;
    logic                din_ready_r, dout_valid_r, dout_last_r, busy_r;
    logic [CW-1:0]       dout_chan_r;

    logic signed [PW-1:0] x_ext_s, d_ext_s, fb_ext_s, wet_ext_s, dry_ext_s;
    logic signed [PW-1:0] prod_fb_s, prod_dry_s, prod_wet_s;
    logic signed [SW-1:0] w_sum_s, y_sum_s;
    logic signed [W-1:0]  w_val_s, y_val_s;

    logic signed [W-1:0] mem [0:(1<<AW)-1];

    assign stream.din_ready  = din_ready_r;
    assign stream.dout       = dout_r;
    assign stream.dout_valid = dout_valid_r;
    assign stream.dout_chan  = dout_chan_r;
    assign stream.dout_last  = dout_last_r;
    assign busy_clearing     = busy_r;

    // Comb filter datapath: gains are unsigned 1.15 so they are zero-extended before the signed multiply.
    always_comb begin
        x_ext_s    = PW'(x_r);
        d_ext_s    = PW'(rd_data_r);
        fb_ext_s   = {{(PW-16){1'b0}}, fb_r};
        wet_ext_s  = {{(PW-16){1'b0}}, wet_r};
        dry_ext_s  = {{(PW-16){1'b0}}, dry_r};
        prod_fb_s  = d_ext_s * fb_ext_s;
        prod_dry_s = x_ext_s * dry_ext_s;
        prod_wet_s = d_ext_s * wet_ext_s;
        w_sum_s    = SW'(x_ext_s) + SW'(prod_fb_s >>> 15);
        y_sum_s    = SW'(prod_dry_s) + SW'(prod_wet_s);
        w_val_s    = sat(w_sum_s);
        y_val_s    = bypass_r ? x_r : sat(y_sum_s >>> 15);
    end

    // Write port: zero-fill while clearing, store the new comb state in CALC.
    always_comb begin
        accept_s   = stream.din_valid && din_ready_r && (state_r == S_IDLE);
        clr_last_s = (clr_ch_r == LAST_CH) && (&clr_ptr_r);
        wr_en_s    = (state_r == S_CLEAR) || (state_r == S_CALC);
        if (state_r == S_CALC) begin
            wr_addr_s = {ptr_r, ch_r};
            wr_data_s = w_val_s;
        end else begin
            wr_addr_s = {clr_ptr_r, clr_ch_r};
            wr_data_s = {W{1'b0}};
        end
    end

    // Next-state logic for the one-sample-in-flight sequencer.
    always_comb begin
        state_next = state_r;
        case (state_r)
            S_CLEAR: state_next = clr_last_s ? S_IDLE : S_CLEAR;
            S_IDLE:  state_next = accept_s ? S_READ : S_IDLE;
            S_READ:  state_next = S_CALC;
            S_CALC:  state_next = S_OUT;
            S_OUT:   state_next = stream.dout_ready ? S_IDLE : S_OUT;
            default: state_next = S_CLEAR;
        endcase
    end

    // Delay-line RAM with a registered read port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
        end
        rd_data_r <= mem[rd_addr_r];
    end

    // Sequencer state, captured sample/controls and registered outputs.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state_r      <= S_CLEAR;
            ch_r         <= {CW{1'b0}};
            ptr_r        <= {DW{1'b0}};
            clr_ch_r     <= {CW{1'b0}};
            clr_ptr_r    <= {DW{1'b0}};
            rd_addr_r    <= {AW{1'b0}};
            x_r          <= {W{1'b0}};
            fb_r         <= 16'h0000;
            wet_r        <= 16'h0000;
            dry_r        <= 16'h0000;
            bypass_r     <= 1'b0;
            din_ready_r  <= 1'b0;
            dout_valid_r <= 1'b0;
            dout_r       <= {W{1'b0}};
            dout_chan_r  <= {CW{1'b0}};
            dout_last_r  <= 1'b0;
            busy_r       <= 1'b1;
        end else begin
            state_r     <= state_next;
            din_ready_r <= (state_next == S_IDLE);
            busy_r      <= (state_next == S_CLEAR);
            case (state_r)
                S_CLEAR: begin
                    if (clr_ch_r == LAST_CH) begin
                        clr_ch_r  <= {CW{1'b0}};
                        clr_ptr_r <= clr_ptr_r + DW'(1);
                    end else begin
                        clr_ch_r <= clr_ch_r + CW'(1);
                    end
                end
                S_IDLE: begin
                    if (accept_s) begin
                        x_r       <= stream.din;
                        bypass_r  <= bypass;
                        fb_r      <= feedback_gain;
                        wet_r     <= wet_gain;
                        dry_r     <= dry_gain;
                        // delay_len of 0 lands on the slot about to be overwritten: full depth.
                        rd_addr_r <= {ptr_r - delay_len, ch_r};
                    end
                end
                S_CALC: begin
                    dout_r       <= y_val_s;
                    dout_chan_r  <= ch_r;
                    dout_last_r  <= (ch_r == LAST_CH);
                    dout_valid_r <= 1'b1;
                end
                S_OUT: begin
                    if (stream.dout_ready) begin
                        dout_valid_r <= 1'b0;
                        if (ch_r == LAST_CH) begin
                            ch_r  <= {CW{1'b0}};
                            ptr_r <= ptr_r + DW'(1);
                        end else begin
                            ch_r <= ch_r + CW'(1);
                        end
                    end
                end
                default: begin
                    dout_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multichannel_feedback_reverb.sv
// Directed bench for the feedback reverb (2 channels, depth 16) with a behavioural
// delay-line model feeding a scoreboard of expected outputs.
module tb_multichannel_feedback_reverb;
    logic        clk = 1'b0;
    logic        reset, enable, bypass, busy;
    logic [15:0] fb, wet, dry;
    logic [3:0]  dl;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct packed { logic [15:0] data; logic chan; logic last; } exp_t;
    exp_t        sb[$];
    int          m_mem [2][16];
    int          m_ch, m_ptr;
    logic [15:0] t2 [10];
    logic [15:0] got, xin;
    int          cnt;

    multichannel_feedback_reverb_if #(.DATA_WIDTH(16), .CH_WIDTH(1)) bus ();

    multichannel_feedback_reverb #(
        .G_DATA_WIDTH(16), .G_NUM_CH(2), .G_DELAY_DEPTH_LOG2(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bypass(bypass),
        .feedback_gain(fb), .wet_gain(wet), .dry_gain(dry), .delay_len(dl),
        .busy_clearing(busy), .stream(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, o, e);
        end
    endtask

    function automatic int msat(input longint v);
        if (v > 32767) return 32767;
        else if (v < -32768) return -32768;
        else return int'(v);
    endfunction

    task automatic model_reset();
        foreach (m_mem[i, j]) m_mem[i][j] = 0;
        m_ch  = 0;
        m_ptr = 0;
        sb.delete();
    endtask

    task automatic model_push(input logic [15:0] x);
        longint xs, d, w, y;
        exp_t   e;
        xs = longint'($signed(x));
        d  = longint'(m_mem[m_ch][(m_ptr - int'(dl)) & 15]);
        w  = msat(xs + ((d * longint'(fb)) >>> 15));
        y  = bypass ? xs : msat((xs * longint'(dry) + d * longint'(wet)) >>> 15);
        m_mem[m_ch][m_ptr] = int'(w);
        e.data = y[15:0];
        e.chan = m_ch[0];
        e.last = (m_ch == 1);
        sb.push_back(e);
        if (m_ch == 1) begin
            m_ch  = 0;
            m_ptr = (m_ptr + 1) & 15;
        end else begin
            m_ch = 1;
        end
    endtask

    task automatic wait_clear();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b0) check("tmo_clear", {31'd0, busy}, 32'd0);
        model_reset();
    endtask

    task automatic do_reset();
        bus.din_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_clear();
    endtask

    task automatic send(input logic [15:0] x);
        int t;
        t = 0;
        while (bus.din_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (bus.din_ready !== 1'b1) check("tmo_din_ready", {31'd0, bus.din_ready}, 32'd1);
        bus.din       = x;
        bus.din_valid = 1'b1;
        model_push(x);
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic recv(input int stall, output logic [15:0] y);
        int          t;
        exp_t        e;
        logic [15:0] held;
        t = 0;
        while (bus.dout_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (bus.dout_valid !== 1'b1) check("tmo_dout_valid", {31'd0, bus.dout_valid}, 32'd1);
        if (stall > 0) begin
            bus.dout_ready = 1'b0;
            held           = bus.dout;
            bus.din        = 16'hDEAD;
            bus.din_valid  = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check("stall_dout", {16'd0, bus.dout}, {16'd0, held});
                check("stall_valid", {31'd0, bus.dout_valid}, 32'd1);
                check("stall_din_ready", {31'd0, bus.din_ready}, 32'd0);
            end
            bus.din_valid  = 1'b0;
            bus.dout_ready = 1'b1;
        end
        y = bus.dout;
        if (sb.size() == 0) begin
            check("sb_size", sb.size(), 32'd1);
        end else begin
            e = sb.pop_front();
            check("dout", {16'd0, bus.dout}, {16'd0, e.data});
            check("dout_chan", {31'd0, bus.dout_chan}, {31'd0, e.chan});
            check("dout_last", {31'd0, bus.dout_last}, {31'd0, e.last});
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; bypass = 1'b0;
        fb = 16'h0000; wet = 16'h8000; dry = 16'h8000; dl = 4'd3;
        bus.din = 16'h0000; bus.din_valid = 1'b0; bus.dout_ready = 1'b1;
        t2 = '{16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h0000,
               16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h1000};

        // reset values and clear duration
        repeat (3) @(negedge clk);
        check("rst_din_ready", {31'd0, bus.din_ready}, 32'd0);
        check("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("rst_dout", {16'd0, bus.dout}, 32'd0);
        check("rst_dout_chan", {31'd0, bus.dout_chan}, 32'd0);
        check("rst_dout_last", {31'd0, bus.dout_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            check("clr_din_ready", {31'd0, bus.din_ready}, 32'd0);
            cnt++;
            @(negedge clk);
        end
        check("clr_cycles", cnt, 32'd32);
        check("clr_done_ready", {31'd0, bus.din_ready}, 32'd1);
        model_reset();

        // impulse echo on ch0 only; second run stalls the output for 10 cycles
        for (int run = 0; run < 2; run++) begin
            if (run == 1) do_reset();
            fb = 16'h4000;
            dl = 4'd3;
            for (int i = 0; i < 10; i++) begin
                send((i == 0) ? 16'h4000 : 16'h0000);
                recv((run == 1 && i == 3) ? 10 : 0, got);
                check("impulse_ch0", {16'd0, got}, {16'd0, t2[i]});
                send(16'h0000);
                recv(0, got);
                check("impulse_ch1", {16'd0, got}, 32'd0);
            end
        end

        // unity feedback saturates at both rails
        fb = 16'h8000;
        dl = 4'd1;
        for (int s = 0; s < 2; s++) begin
            do_reset();
            xin = (s == 0) ? 16'h7FFF : 16'h8000;
            for (int i = 0; i < 16; i++) begin
                send(xin);
                recv(0, got);
            end
            check("sat_final", {16'd0, got}, {16'd0, xin});
        end

        // reset while the impulse is in CALC drops it and erases the line
        do_reset();
        fb = 16'h4000;
        dl = 4'd3;
        bus.din = 16'h4000;
        bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, bus.dout_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        check("mid_rst_ready", {31'd0, bus.din_ready}, 32'd0);
        reset = 1'b0;
        wait_clear();
        for (int i = 0; i < 16; i++) begin
            send(16'h0000);
            recv(0, got);
            check("post_rst_zero", {16'd0, got}, 32'd0);
        end

        // bypass passes the dry sample straight through
        bypass = 1'b1;
        for (int i = 0; i < 6; i++) begin
            xin = (i == 0) ? 16'h8001 : 16'($urandom_range(0, 65535));
            send(xin);
            recv(0, got);
            check("bypass", {16'd0, got}, {16'd0, xin});
        end
        bypass = 1'b0;

        // enable low behaves as reset
        enable = 1'b0;
        @(negedge clk);
        check("en_busy", {31'd0, busy}, 32'd1);
        check("en_ready", {31'd0, bus.din_ready}, 32'd0);
        enable = 1'b1;
        wait_clear();

        // random gains, delays and samples against the model
        for (int r = 0; r < 3; r++) begin
            fb  = 16'($urandom_range(0, 65535));
            wet = 16'($urandom_range(0, 65535));
            dry = 16'($urandom_range(0, 65535));
            dl  = 4'($urandom_range(0, 15));
            for (int i = 0; i < 12; i++) begin
                send(16'($urandom_range(0, 65535)));
                recv(0, got);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
